// File: rtl/nfu_3_pwl_pkg.sv
// Shared definitions for the NFU-3 piecewise-linear activation stage:
// mode encodings, coefficient word layout and saturation bounds.
// Optional feature macro: NFU3_PWL_RELU_EN (enables ReLU in mode 2).
package nfu_3_pwl_pkg;

  // Runtime activation mode; both 0 and 3 select the PWL datapath.
  typedef enum logic [1:0] {
    MODE_PWL     = 2'd0,
    MODE_IDENT   = 2'd1,
    MODE_RELU    = 2'd2,
    MODE_PWL_ALT = 2'd3
  } mode_e;

  // Coefficient word is {a, b}: each half is N bits, a in the upper half.
  localparam int COEF_A_HALF = 1;
  localparam int COEF_B_HALF = 0;

  // Largest representable signed N-bit value.
  function automatic longint sat_hi(input int n);
    sat_hi = (longint'(1) <<< (n - 1)) - longint'(1);
  endfunction

  // Smallest representable signed N-bit value.
  function automatic longint sat_lo(input int n);
    sat_lo = -(longint'(1) <<< (n - 1));
  endfunction

endpackage

// File: rtl/nfu_3_pwl_lane.sv
// One PWL lane: private coefficient table copy (synchronous, read-first),
// signed multiply, arithmetic shift, bias add and saturation.
// Mode 2 performs ReLU only when NFU3_PWL_RELU_EN is defined; otherwise it
// falls back to identity and no compare logic is built.
module nfu_3_pwl_lane
  import nfu_3_pwl_pkg::*;
#(
  parameter int N        = 16,
  parameter int FRAC     = 8,
  parameter int SEG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adv,
  input  logic                coef_we,
  input  logic [SEG_BITS-1:0] coef_addr,
  input  logic [2*N-1:0]      coef,
  input  logic [N-1:0]        x_in,
  input  mode_e               mode_s2,
  output logic [N-1:0]        y,
  output logic                sat
);

  localparam int NSEG = 1 << SEG_BITS;
  localparam logic signed [2*N:0] SUM_HI = (2*N+1)'(sat_hi(N));
  localparam logic signed [2*N:0] SUM_LO = (2*N+1)'(sat_lo(N));

  logic [SEG_BITS-1:0]   seg_s;
  logic [2*N-1:0]        tbl_q [NSEG];
  logic [2*N-1:0]        coef0_q, coef0_d;
  logic signed [N-1:0]   x0_q, x0_d;
  logic signed [N-1:0]   x1_q, x1_d;
  logic signed [N-1:0]   b1_q, b1_d;
  logic signed [2*N-1:0] p1_q, p1_d;
  logic [N-1:0]          y_q, y_d;
  logic                  sat_q, sat_d;
  logic signed [2*N-1:0] xe_s, ae_s, sh_s;
  logic signed [2*N:0]   sum_s;
  logic [N-1:0]          pwl_y_s, res_y_s;
  logic                  pwl_sat_s, res_sat_s;

  // Flipping the sign bit makes the segment index monotonic over signed x.
  assign seg_s = {~x_in[N-1], x_in[N-2 -: SEG_BITS-1]};

  // Coefficient table write; independent of stall and never reset.
  always_ff @(posedge clk) begin
    if (coef_we) begin
      tbl_q[coef_addr] <= coef;
    end
  end

  // Sign-extend operands so the 2N-bit product is exact.
  always_comb begin
    xe_s = {{N{x0_q[N-1]}}, x0_q};
    ae_s = {{N{coef0_q[COEF_A_HALF*N + N - 1]}}, coef0_q[COEF_A_HALF*N +: N]};
  end

  // S2 arithmetic: floor shift, bias add at 2N+1 bits, clip to N bits.
  always_comb begin
    sh_s  = p1_q >>> FRAC;
    sum_s = {sh_s[2*N-1], sh_s} + {{(N+1){b1_q[N-1]}}, b1_q};
    if (sum_s > SUM_HI) begin
      pwl_y_s   = SUM_HI[N-1:0];
      pwl_sat_s = 1'b1;
    end else if (sum_s < SUM_LO) begin
      pwl_y_s   = SUM_LO[N-1:0];
      pwl_sat_s = 1'b1;
    end else begin
      pwl_y_s   = sum_s[N-1:0];
      pwl_sat_s = 1'b0;
    end
  end

  // Select the lane result from the mode that travelled with this vector.
  always_comb begin
    case (mode_s2)
      MODE_IDENT: begin
        res_y_s   = x1_q;
        res_sat_s = 1'b0;
      end
`ifdef NFU3_PWL_RELU_EN
      MODE_RELU: begin
        res_y_s   = x1_q[N-1] ? {N{1'b0}} : x1_q;
        res_sat_s = 1'b0;
      end
`else
      MODE_RELU: begin
        res_y_s   = x1_q;
        res_sat_s = 1'b0;
      end
`endif
      MODE_PWL, MODE_PWL_ALT: begin
        res_y_s   = pwl_y_s;
        res_sat_s = pwl_sat_s;
      end
      default: begin
        res_y_s   = pwl_y_s;
        res_sat_s = pwl_sat_s;
      end
    endcase
  end

  // Next-state for all lane pipeline registers; stall freezes everything.
  always_comb begin
    if (adv) begin
      x0_d    = x_in;
      coef0_d = tbl_q[seg_s];
      p1_d    = xe_s * ae_s;
      b1_d    = coef0_q[COEF_B_HALF*N +: N];
      x1_d    = x0_q;
      y_d     = res_y_s;
      sat_d   = res_sat_s;
    end else begin
      x0_d    = x0_q;
      coef0_d = coef0_q;
      p1_d    = p1_q;
      b1_d    = b1_q;
      x1_d    = x1_q;
      y_d     = y_q;
      sat_d   = sat_q;
    end
  end

  // Lane pipeline registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q    <= {N{1'b0}};
      coef0_q <= {(2*N){1'b0}};
      p1_q    <= {(2*N){1'b0}};
      b1_q    <= {N{1'b0}};
      x1_q    <= {N{1'b0}};
      y_q     <= {N{1'b0}};
      sat_q   <= 1'b0;
    end else begin
      x0_q    <= x0_d;
      coef0_q <= coef0_d;
      p1_q    <= p1_d;
      b1_q    <= b1_d;
      x1_q    <= x1_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
    end
  end

  assign y   = y_q;
  assign sat = sat_q;

endmodule

// File: rtl/nfu_3_pwl.sv
// NFU-3 PWL activation top: Tn lanes plus the shared valid/mode pipeline.
// Three register stages; a stall freezes every stage including outputs.
// Optional feature macro: NFU3_PWL_RELU_EN (mode 2 = ReLU when defined).
module nfu_3_pwl
  import nfu_3_pwl_pkg::*;
#(
  parameter int N        = 16,
  parameter int Tn       = 16,
  parameter int FRAC     = 8,
  parameter int SEG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  input  logic                i_stall,
  input  logic [1:0]          i_mode,
  input  logic [Tn*N-1:0]     i_nfu2_out,
  input  logic                i_coef_we,
  input  logic [SEG_BITS-1:0] i_coef_addr,
  input  logic [2*N-1:0]      i_coef,
  output logic                o_valid,
  output logic [Tn*N-1:0]     o_nfu3_out,
  output logic [Tn-1:0]       o_sat
);

  logic  adv_s;
  logic  v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  mode_e mode0_q, mode0_d, mode1_q, mode1_d;

  assign adv_s = ~i_stall;

  // Valid and mode travel alongside the lane data; i_valid ignored on stall.
  always_comb begin
    if (adv_s) begin
      v0_d    = i_valid;
      mode0_d = mode_e'(i_mode);
      v1_d    = v0_q;
      mode1_d = mode0_q;
      v2_d    = v1_q;
    end else begin
      v0_d    = v0_q;
      mode0_d = mode0_q;
      v1_d    = v1_q;
      mode1_d = mode1_q;
      v2_d    = v2_q;
    end
  end

  // Shared control pipeline registers; reset discards in-flight vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      mode0_q <= MODE_PWL;
      mode1_q <= MODE_PWL;
    end else begin
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      mode0_q <= mode0_d;
      mode1_q <= mode1_d;
    end
  end

  assign o_valid = v2_q;

  for (genvar g = 0; g < Tn; g++) begin : g_lane
    nfu_3_pwl_lane #(
      .N        (N),
      .FRAC     (FRAC),
      .SEG_BITS (SEG_BITS)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv_s),
      .coef_we   (i_coef_we),
      .coef_addr (i_coef_addr),
      .coef      (i_coef),
      .x_in      (i_nfu2_out[g*N +: N]),
      .mode_s2   (mode1_q),
      .y         (o_nfu3_out[g*N +: N]),
      .sat       (o_sat[g])
    );
  end

endmodule

// File: tb/tb_nfu_3_pwl.sv
// Scoreboard bench for nfu_3_pwl: stimulus pushes expected vectors, a
// negedge monitor pops and compares whenever an output is accepted.
module tb_nfu_3_pwl;
  localparam int N  = 16;
  localparam int TN = 16;
  localparam int SB = 4;
  localparam int W  = TN * N;

`ifdef NFU3_PWL_RELU_EN
  localparam logic [N-1:0] RELU_NEG_EXP = 16'h0000;
`else
  localparam logic [N-1:0] RELU_NEG_EXP = 16'hFF00;
`endif

  typedef struct packed {
    logic [W-1:0]  y;
    logic [TN-1:0] s;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, i_stall, i_coef_we;
  logic [1:0]    i_mode;
  logic [W-1:0]  i_nfu2_out;
  logic [SB-1:0] i_coef_addr;
  logic [2*N-1:0] i_coef;
  logic          o_valid;
  logic [W-1:0]  o_nfu3_out;
  logic [TN-1:0] o_sat;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic           wr_pend = 1'b0;
  logic [SB-1:0]  wr_addr;
  logic [2*N-1:0] wr_coef;

  logic          hold_chk = 1'b0;
  logic [W-1:0]  hold_y;
  logic [TN-1:0] hold_s;

  logic [W-1:0]  xv, ev;
  logic [TN-1:0] sv;

  nfu_3_pwl #(.N(N), .Tn(TN), .FRAC(8), .SEG_BITS(SB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .i_stall     (i_stall),
    .i_mode      (i_mode),
    .i_nfu2_out  (i_nfu2_out),
    .i_coef_we   (i_coef_we),
    .i_coef_addr (i_coef_addr),
    .i_coef      (i_coef),
    .o_valid     (o_valid),
    .o_nfu3_out  (o_nfu3_out),
    .o_sat       (o_sat)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rep(input logic [N-1:0] v);
    rep = {TN{v}};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // One input cycle; pending coefficient write goes out in the same cycle.
  task automatic drive(input logic v, input logic st, input logic [1:0] m,
                       input logic [W-1:0] x, input logic [W-1:0] ey,
                       input logic [TN-1:0] es);
    exp_t e;
    @(posedge clk);
    #1;
    i_valid     = v;
    i_stall     = st;
    i_mode      = m;
    i_nfu2_out  = x;
    i_coef_we   = wr_pend;
    i_coef_addr = wr_addr;
    i_coef      = wr_coef;
    wr_pend     = 1'b0;
    if (v && !st) begin
      e.y = ey;
      e.s = es;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, {W{1'b0}}, {W{1'b0}}, {TN{1'b0}});
  endtask

  task automatic wcoef(input logic [SB-1:0] addr, input logic [N-1:0] a, input logic [N-1:0] b);
    wr_pend = 1'b1;
    wr_addr = addr;
    wr_coef = {a, b};
    idle();
  endtask

  // Monitor: outputs are consumed only on cycles without stall.
  always @(negedge clk) begin
    exp_t e;
    if (hold_chk) begin
      n_tests++;
      if (o_valid !== 1'b1 || o_nfu3_out !== hold_y || o_sat !== hold_s) begin
        n_fail++;
        $display("FAIL stall_hold valid=%b y got %h exp %h sat got %h exp %h",
                 o_valid, o_nfu3_out, hold_y, o_sat, hold_s);
      end
    end
    hold_chk = 1'b0;
    if (o_valid === 1'b1) begin
      if (i_stall === 1'b1) begin
        hold_chk = 1'b1;
        hold_y   = o_nfu3_out;
        hold_s   = o_sat;
      end else begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out got %h exp none", o_nfu3_out);
        end else begin
          e = sb.pop_front();
          if (o_nfu3_out !== e.y || o_sat !== e.s) begin
            n_fail++;
            $display("FAIL out_vec y got %h exp %h sat got %h exp %h",
                     o_nfu3_out, e.y, o_sat, e.s);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got running exp finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_stall = 1'b0; i_mode = 2'd0;
    i_nfu2_out = {W{1'b0}}; i_coef_we = 1'b0; i_coef_addr = {SB{1'b0}};
    i_coef = {(2*N){1'b0}}; wr_addr = {SB{1'b0}}; wr_coef = {(2*N){1'b0}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", W'(o_valid), {W{1'b0}});
    chk("reset_out", o_nfu3_out, {W{1'b0}});
    chk("reset_sat", W'(o_sat), {W{1'b0}});
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Unity slope everywhere: y = x.
    for (int s = 0; s < 16; s++) wcoef(SB'(s), 16'h0100, 16'h0000);
    drive(1'b1, 1'b0, 2'd0, rep(16'h0280), rep(16'h0280), 16'h0000);
    for (int i = 0; i < TN; i++) xv[i*N +: N] = 16'(i * 16'h1111);
    drive(1'b1, 1'b0, 2'd0, xv, xv, 16'h0000);
    idle();

    // Distinct slope/bias on the extreme and middle segments.
    wcoef(4'd0, 16'h0080, 16'hFF00);
    wcoef(4'd8, 16'h0200, 16'h0040);
    drive(1'b1, 1'b0, 2'd0, rep(16'h8000), rep(16'hBF00), 16'h0000);
    drive(1'b1, 1'b0, 2'd0, rep(16'h0010), rep(16'h0060), 16'h0000);

    // Saturation at both ends, then a per-lane mix.
    wcoef(4'd15, 16'h7FFF, 16'h7FFF);
    drive(1'b1, 1'b0, 2'd0, rep(16'h7FFF), rep(16'h7FFF), 16'hFFFF);
    wcoef(4'd0, 16'h7FFF, 16'h8000);
    drive(1'b1, 1'b0, 2'd0, rep(16'h8000), rep(16'h8000), 16'hFFFF);
    for (int i = 0; i < TN; i++) begin
      xv[i*N +: N] = (i % 2 == 0) ? 16'h7FFF : 16'h0010;
      ev[i*N +: N] = (i % 2 == 0) ? 16'h7FFF : 16'h0060;
    end
    drive(1'b1, 1'b0, 2'd0, xv, ev, 16'h5555);
    idle();

    // Five vectors with a two-cycle stall; junk offered during the stall.
    drive(1'b1, 1'b0, 2'd0, rep(16'h1000), rep(16'h1000), 16'h0000);
    drive(1'b1, 1'b0, 2'd0, rep(16'h2000), rep(16'h2000), 16'h0000);
    drive(1'b1, 1'b0, 2'd0, rep(16'h3000), rep(16'h3000), 16'h0000);
    drive(1'b1, 1'b1, 2'd0, rep(16'h5555), {W{1'b0}}, 16'h0000);
    drive(1'b1, 1'b1, 2'd0, rep(16'h5555), {W{1'b0}}, 16'h0000);
    drive(1'b1, 1'b0, 2'd0, rep(16'hF000), rep(16'hF000), 16'h0000);
    drive(1'b1, 1'b0, 2'd0, rep(16'hE000), rep(16'hE000), 16'h0000);
    repeat (3) idle();

    // Read-first: write and read seg 8 in the same cycle.
    wcoef(4'd8, 16'h0100, 16'h0000);
    wr_pend = 1'b1; wr_addr = 4'd8; wr_coef = {16'h0200, 16'h0000};
    drive(1'b1, 1'b0, 2'd0, rep(16'h0100), rep(16'h0100), 16'h0000);
    drive(1'b1, 1'b0, 2'd0, rep(16'h0100), rep(16'h0200), 16'h0000);

    // Back-to-back mode changes.
    drive(1'b1, 1'b0, 2'd1, rep(16'h8000), rep(16'h8000), 16'h0000);
    drive(1'b1, 1'b0, 2'd2, rep(16'hFF00), rep(RELU_NEG_EXP), 16'h0000);
    drive(1'b1, 1'b0, 2'd3, rep(16'h0010), rep(16'h0020), 16'h0000);
    drive(1'b1, 1'b0, 2'd0, rep(16'h7FFF), rep(16'h7FFF), 16'hFFFF);
    idle();
    drive(1'b1, 1'b0, 2'd1, rep(16'hFF00), rep(16'hFF00), 16'h0000);
    repeat (4) idle();

    // Reset while vectors are in flight and one is on the output.
    drive(1'b1, 1'b0, 2'd0, rep(16'h1000), rep(16'h1000), 16'h0000);
    drive(1'b1, 1'b0, 2'd0, rep(16'h2000), rep(16'h2000), 16'h0000);
    drive(1'b1, 1'b0, 2'd0, rep(16'h3000), rep(16'h3000), 16'h0000);
    drive(1'b1, 1'b0, 2'd0, rep(16'hE000), rep(16'hE000), 16'h0000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("midrst_valid", W'(o_valid), {W{1'b0}});
    chk("midrst_out", o_nfu3_out, {W{1'b0}});
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) idle();
    drive(1'b1, 1'b0, 2'd0, rep(16'hF000), rep(16'hF000), 16'h0000);
    idle();

    for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
    repeat (6) @(posedge clk);
    chk("drain_empty", W'(sb.size()), {W{1'b0}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nfu_3_pwl.md
Name: nfu_3_pwl

Overview:
- Parametrised successor of the NFU-3 activation stage: Tn lanes of piecewise-linear (PWL) activation, y = sat((x*a_i >> FRAC) + b_i).
- Generalised over width, fractional point, segment count and lane count; adds a valid/stall pipeline, runtime mode select, addressed coefficient loading and per-lane saturation flags.
- Sits between NFU-2 output and the output buffer.

Parameters:
- N, 16, data width in bits (signed two's complement, all values).
- Tn, 16, lane count.
- FRAC, 8, fractional bits of x, a, b and y (Q(N-FRAC).FRAC).
- SEG_BITS, 4, log2 of segment count; 2..(N-1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  lane vector valid.
- i_stall  in  1  downstream stall; freezes pipeline.
- i_mode  in  2  0=PWL, 1=identity, 2=ReLU (macro-gated), 3=PWL.
- i_nfu2_out  in  Tn*N  input vector, lane i at [(i+1)*N-1 : i*N].
- i_coef_we  in  1  coefficient write enable.
- i_coef_addr  in  SEG_BITS  segment index written.
- i_coef  in  2*N  {a[N-1:0], b[N-1:0]}, a in upper half.
- o_valid  out  1  output valid.
- o_nfu3_out  out  Tn*N  result vector.
- o_sat  out  Tn  per-lane saturation flag, qualified by o_valid.

Behaviour:
- Reset: o_valid=0, o_nfu3_out=0, o_sat=0, all pipeline regs and valid bits=0. Coefficient table is NOT reset (contents undefined until loaded). Reset mid-operation discards in-flight data; first o_valid earliest 3 cycles after the first i_valid following deassertion.
- Segment index per lane: seg = {~x[N-1], x[N-2 -: SEG_BITS-1]}. Monotonic over the signed range: 0x8000 -> 0, 0x0000 -> 2^(SEG_BITS-1), 0x7FFF -> 2^SEG_BITS-1.
- Pipeline, 3 stages, latency 3 cycles when not stalled:
  - S0: register x, mode, valid; coefficient table read (synchronous read, one table copy per lane, all copies written together).
  - S1: signed product p = x*a, 2N bits; register p, b, x, mode, valid.
  - S2: s = (p >>> FRAC) + sign-extended b, evaluated at 2N+1 bits. Result saturates to [-2^(N-1), 2^(N-1)-1]; o_sat=1 when clipped. Register to outputs.
- Shift is arithmetic truncation toward -inf; no rounding.
- Mode applies at S2 using the mode carried with the data:
  - identity: y = x, o_sat=0.
  - ReLU: y = x<0 ? 0 : x, o_sat=0.
  - Mode changes never corrupt in-flight vectors.
- i_stall=1: every pipeline register including o_valid and outputs holds; i_valid is ignored that cycle. The producer must hold or re-present its data.
- Coefficient writes:
  - Take effect at the clock edge and ignore i_stall.
  - Same-cycle write and read of the same address returns the OLD value (read-first).
  - Writes during streaming are legal; a vector uses whatever coefficients it read in S0.
- Bubbles: i_valid=0 produces o_valid=0 three cycles later. Data registers may update freely on bubbles; o_valid is the only qualifier.

Optional Feature:
- Macro: NFU3_PWL_RELU_EN.
- Defined: mode 2 performs ReLU as above.
- Undefined: mode 2 behaves as identity and no ReLU compare logic is built. All other behaviour is unchanged.

Decomposition:
- Shared package holds: mode encodings (MODE_PWL, MODE_IDENT, MODE_RELU), the coefficient word layout {a,b}, and a saturation-bounds helper function of N.
- One natural sub-module: nfu_3_pwl_lane, containing one lane's table copy, multiplier, adder and saturation.
- The top generates Tn lane instances and owns the shared valid/mode/stall pipeline.

Test Plan (N=16, FRAC=8, SEG_BITS=4, Tn=16):
- Load all 16 segments with a=0x0100, b=0. Stream x=0x0280 on all lanes -> 0x0280 on o_nfu3_out exactly 3 cycles later, o_sat=0.
- Load seg 0 with a=0x0080, b=0xFF00 and seg 8 with a=0x0200, b=0x0040.
  - x=0x8000 -> 0xBF00 (-0x4000 - 0x100).
  - x=0x0010 -> 0x0060.
- Load seg 15 with a=0x7FFF, b=0x7FFF. x=0x7FFF -> 0x7FFF with o_sat=1. Negative mirror case: seg 0 with a=0x7FFF, b=0x8000, x=0x8000 -> 0x8000 with o_sat=1.
- Stream 5 consecutive vectors; assert i_stall for 2 cycles mid-stream -> outputs and o_valid hold. All 5 emerge in order with no loss or duplication.
- Same cycle: write seg 8 (a=0x0200, b=0) and present x=0x0100 (reading seg 8 with old a=0x0100) -> 0x0100. The next x=0x0100 -> 0x0200.
- Mode 1 on x=0xFF00 -> 0xFF00. Mode 2 -> 0x0000 with NFU3_PWL_RELU_EN defined, 0xFF00 without it. Pulse rst_n low mid-stream -> o_valid=0 immediately and no stale vectors after release.
